hazard_id_ex: RTL
=================

HAZARD_ID_EX -- requirements
Module: hazard_id_ex

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports are clk and reset.
REQ-002 SHALL provide ports (name direction width meaning), clock and reset first:
- clk in 1: rising-edge clock.
- reset in 1: synchronous active-high reset.
- ValidD in 1: decode slot holds a real instruction.
- RsD, RtD, RdD in 5 each: decode register fields.
- RD1D, RD2D, SignImmD in 32 each: decode operands and sign-extended immediate.
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD in 1 each: decode controls.
- ALUControlD in 3: decode ALU op.
- BranchD, BranchNotD in 1 each: beq / bne in decode.
- WriteRegM in 5, MemtoRegM in 1: memory-stage destination and load flag.
- FlushExtE in 1: external request to squash the instruction entering EX (redirect).
- RsE, RtE, RdE out 5 each: EX register fields (feed the EX forwarding unit).
- RD1E, RD2E, SignImmE out 32 each: EX operands.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE out 1 each; ALUControlE out 3.
- ValidE out 1: EX slot holds a real instruction.
- WriteRegE out 5: combinational, RegDstE ? RdE : RtE.
- StallF, StallD, FlushE out 1 each: hazard controls.
- StallCount out 16: saturating count of stall cycles.

Function
REQ-003 SHALL compute lwstall = MemtoRegE & RegWriteE & (RtE != 0) & ((RtE == RsD) | (RtE == RtD)).
REQ-004 SHALL compute branchstall = (BranchD | BranchNotD) & ( (RegWriteE & MemtoRegE & WriteRegE != 0 & (WriteRegE == RsD | WriteRegE == RtD)) | (MemtoRegM & WriteRegM != 0 & (WriteRegM == RsD | WriteRegM == RtD)) ).
REQ-005 SHALL NOT stall a branch on a non-load ALU result in EX; the EX-to-decode branch forwarding path handles it.
REQ-006 SHALL set stall = ValidD & (lwstall | branchstall), then drive StallF = StallD = stall and FlushE = stall | FlushExtE, all combinational from current register state and inputs.
REQ-007 SHALL, on a rising edge with FlushE = 1 and reset = 0, load a bubble into every EX register: all fields, operands and controls 0, ValidE = 0.
REQ-008 SHALL, on a rising edge with FlushE = 0 and reset = 0, capture every D-suffixed input into its E-suffixed register and set ValidE = ValidD.
REQ-009 SHALL give the ID/EX register single-cycle latency: decode values appear on the E outputs the cycle after capture.
REQ-010 SHALL give priority reset > FlushE > capture.
REQ-011 SHALL ensure a stall lasts exactly one cycle for lwstall, because the bubble clears MemtoRegE.
REQ-012 SHALL ensure branchstall lasts at most two cycles: one for a load in EX, one for a load in MEM.
REQ-013 SHALL increment StallCount by 1 on each rising edge where stall = 1, saturate at 16'hFFFF, and SHALL NOT count cycles flushed only by FlushExtE.
REQ-014 SHALL treat register 0 as never a hazard source.
REQ-015 SHALL suppress stall when ValidD = 0, so no stall is raised for a bubble in decode.

Reset
REQ-016 SHALL, on reset = 1 at a rising edge, clear all E registers and ValidE to 0 and StallCount to 0.
REQ-017 SHALL, after reset, drive StallF, StallD and FlushE to 0 unless FlushExtE = 1, since every reset register is 0.
REQ-018 SHALL let reset asserted mid-stall abort the stall: the next cycle has no stall and no retained state.

Verification
REQ-019 Load-use: cycle n EX holds lw with RtE = 8; decode RsD = 8, ValidD = 1 -> StallF = StallD = FlushE = 1 in cycle n; cycle n+1 ValidE = 0, stall = 0; StallCount = 1.
REQ-020 No false stall: EX holds add writing 8, decode beq RsD = 8 -> stall = 0; EX captures beq on the next edge.
REQ-021 Branch after load: lw to 9 in EX, beq RtD = 9 in decode -> stall in 2 consecutive cycles (load in EX, then load in MEM via WriteRegM = 9, MemtoRegM = 1); StallCount += 2; third cycle beq captured.
REQ-022 Register zero: lw RtE = 0, RsD = 0 -> stall = 0.
REQ-023 Flush and saturation: FlushExtE = 1 with no hazard -> FlushE = 1, StallF = 0, next ValidE = 0, StallCount unchanged; preload count at FFFF plus a stall -> stays FFFF.
REQ-024 Reset mid-stall: assert reset during lwstall -> next cycle all E outputs 0, StallCount = 0, stall = 0.

Source files
------------

// File: rtl/hazard_id_ex.sv
// rtl/hazard_id_ex.sv - ID/EX pipeline register with load-use / branch hazard detection
//
// Purpose: holds the decode->execute pipeline register and raises stall/flush
// controls when the instruction in decode needs a loaded value that is not yet
// available (load in EX feeding any use, or load in EX/MEM feeding a branch).
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   ValidD, RsD/RtD/RdD, RD1D/RD2D,
//   SignImmD, *D controls             decode-stage instruction contents
//   BranchD, BranchNotD               beq / bne in decode
//   WriteRegM, MemtoRegM              memory-stage destination and load flag
//   FlushExtE                         external squash of the instruction entering EX
//   *E outputs, ValidE                registered EX-stage contents
//   WriteRegE                         EX destination register (combinational)
//   StallF, StallD, FlushE            hazard controls
//   StallCount                        saturating count of stall cycles

module hazard_id_ex (
    input  logic        clk,
    input  logic        reset,
    input  logic        ValidD,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] SignImmD,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        MemWriteD,
    input  logic        ALUSrcD,
    input  logic        RegDstD,
    input  logic [2:0]  ALUControlD,
    input  logic        BranchD,
    input  logic        BranchNotD,
    input  logic [4:0]  WriteRegM,
    input  logic        MemtoRegM,
    input  logic        FlushExtE,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] SignImmE,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        RegDstE,
    output logic [2:0]  ALUControlE,
    output logic        ValidE,
    output logic [4:0]  WriteRegE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic [15:0] StallCount
);

    logic [4:0]  r_rs_e;
    logic [4:0]  r_rt_e;
    logic [4:0]  r_rd_e;
    logic [31:0] r_rd1_e;
    logic [31:0] r_rd2_e;
    logic [31:0] r_imm_e;
    logic        r_regwrite_e;
    logic        r_memtoreg_e;
    logic        r_memwrite_e;
    logic        r_alusrc_e;
    logic        r_regdst_e;
    logic [2:0]  r_aluctl_e;
    logic        r_valid_e;
    logic [15:0] r_stall_count;

    logic [4:0]  w_writereg_e;
    logic        w_lwstall;
    logic        w_ex_load_hit;
    logic        w_mem_load_hit;
    logic        w_branchstall;
    logic        w_stall;
    logic        w_flush_e;

    assign w_writereg_e = r_regdst_e ? r_rd_e : r_rt_e;

    // Load in EX whose target is read by the decode instruction.
    assign w_lwstall = r_memtoreg_e && r_regwrite_e && (r_rt_e != 5'd0) &&
                       ((r_rt_e == RsD) || (r_rt_e == RtD));

    // Branches compare in decode, so they must also wait for a load sitting
    // in MEM. Non-load ALU results in EX are forwarded to decode instead.
    assign w_ex_load_hit  = r_regwrite_e && r_memtoreg_e && (w_writereg_e != 5'd0) &&
                            ((w_writereg_e == RsD) || (w_writereg_e == RtD));
    assign w_mem_load_hit = MemtoRegM && (WriteRegM != 5'd0) &&
                            ((WriteRegM == RsD) || (WriteRegM == RtD));
    assign w_branchstall  = (BranchD || BranchNotD) && (w_ex_load_hit || w_mem_load_hit);

    // A bubble in decode never stalls.
    assign w_stall   = ValidD && (w_lwstall || w_branchstall);
    assign w_flush_e = w_stall || FlushExtE;

    always_ff @(posedge clk) begin
        if (reset || w_flush_e) begin
            r_rs_e       <= 5'd0;
            r_rt_e       <= 5'd0;
            r_rd_e       <= 5'd0;
            r_rd1_e      <= 32'd0;
            r_rd2_e      <= 32'd0;
            r_imm_e      <= 32'd0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_memwrite_e <= 1'b0;
            r_alusrc_e   <= 1'b0;
            r_regdst_e   <= 1'b0;
            r_aluctl_e   <= 3'd0;
            r_valid_e    <= 1'b0;
        end else begin
            r_rs_e       <= RsD;
            r_rt_e       <= RtD;
            r_rd_e       <= RdD;
            r_rd1_e      <= RD1D;
            r_rd2_e      <= RD2D;
            r_imm_e      <= SignImmD;
            r_regwrite_e <= RegWriteD;
            r_memtoreg_e <= MemtoRegD;
            r_memwrite_e <= MemWriteD;
            r_alusrc_e   <= ALUSrcD;
            r_regdst_e   <= RegDstD;
            r_aluctl_e   <= ALUControlD;
            r_valid_e    <= ValidD;
        end
    end

    // Only hazard stalls are counted; external flushes alone are not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign RsE         = r_rs_e;
    assign RtE         = r_rt_e;
    assign RdE         = r_rd_e;
    assign RD1E        = r_rd1_e;
    assign RD2E        = r_rd2_e;
    assign SignImmE    = r_imm_e;
    assign RegWriteE   = r_regwrite_e;
    assign MemtoRegE   = r_memtoreg_e;
    assign MemWriteE   = r_memwrite_e;
    assign ALUSrcE     = r_alusrc_e;
    assign RegDstE     = r_regdst_e;
    assign ALUControlE = r_aluctl_e;
    assign ValidE      = r_valid_e;
    assign WriteRegE   = w_writereg_e;
    assign StallF      = w_stall;
    assign StallD      = w_stall;
    assign FlushE      = w_flush_e;
    assign StallCount  = r_stall_count;

endmodule
